// File: rtl/ufi_master_arbiter.sv
// N-master front end for a single UFI slave: round-robin or fixed-priority grants
// with a per-grant beat cap, registered slave issue and ID-routed read return.
module ufi_master_arbiter #(
  parameter int    pUfiBusWidth = 12,
  parameter int    pUsiBusWidth = 32,
  parameter int    pMasterNum   = 4,
  parameter int    pIdWidth     = 3,
  parameter int    pMaxBurst    = 16,
  parameter string pArbMode     = "rr"
) (
  input  logic                                 iSCLK,
  input  logic                                 iSRST,
  input  logic [pMasterNum*pUfiBusWidth-1:0]   iMUfiWd,
  input  logic [pMasterNum*pUsiBusWidth-1:0]   iMUfiAdrs,
  input  logic [pMasterNum-1:0]                iMUfiWEd,
  input  logic [pMasterNum-1:0]                iMUfiREd,
  input  logic [pMasterNum-1:0]                iMUfiCmd,
  input  logic [pMasterNum-1:0]                iMUfiVd,
  output logic [pMasterNum-1:0]                oMUfiRdy,
  output logic [pUfiBusWidth-1:0]              oMUfiRd,
  output logic [pMasterNum-1:0]                oMUfiREd,
  output logic [pUfiBusWidth-1:0]              oSUfiWd,
  output logic [pUsiBusWidth-1:0]              oSUfiAdrs,
  output logic                                 oSUfiWEd,
  output logic                                 oSUfiREd,
  output logic                                 oSUfiCmd,
  output logic [pIdWidth-1:0]                  oSUfiIdO,
  input  logic [pUfiBusWidth-1:0]              iSUfiRd,
  input  logic                                 iSUfiREd,
  input  logic [pIdWidth-1:0]                  iSUfiIdI,
  input  logic                                 iSUfiRdy,
  output logic                                 oGrantVd,
  output logic [pIdWidth-1:0]                  oGrantId
);

  localparam int                 CW        = $clog2(pMaxBurst + 1);
  localparam logic [CW-1:0]      MAX_BEATS = CW'(pMaxBurst);
  localparam logic [pIdWidth-1:0] LAST_ID  = pIdWidth'(pMasterNum - 1);
  localparam bit                 FIXED     = (pArbMode == "fixed");

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t                    r_state, w_state_nxt;
  logic [pIdWidth-1:0]       r_ptr, w_ptr_nxt, w_win, w_gnext;
  logic [CW-1:0]             r_beat, w_beat_nxt;
  logic [pMasterNum-1:0]     w_gsel;
  logic [pUfiBusWidth-1:0]   w_wd_g;
  logic [pUsiBusWidth-1:0]   w_adrs_g;
  logic                      w_vd_g, w_wed_g, w_red_g, w_cmd_g;
  logic                      w_rdy_g, w_acc, w_grant, w_release;

  // Winner = requester with the smallest distance from the priority base
  always_comb begin : p_arb
    int   base;
    int   off;
    int   best_off;
    logic take;
    base     = FIXED ? 0 : int'(r_ptr);
    best_off = pMasterNum;
    off      = 0;
    take     = 1'b0;
    w_win    = '0;
    for (int k = 0; k < pMasterNum; k++) begin
      off      = (k + pMasterNum - base) % pMasterNum;
      take     = iMUfiVd[k] && (off < best_off);
      w_win    = take ? pIdWidth'(k) : w_win;
      best_off = take ? off : best_off;
    end
  end

  always_comb begin : p_gmux
    w_gsel   = '0;
    w_wd_g   = '0;
    w_adrs_g = '0;
    for (int k = 0; k < pMasterNum; k++) begin
      w_gsel[k] = (oGrantId == pIdWidth'(k));
      w_wd_g    = w_wd_g | (iMUfiWd[k*pUfiBusWidth +: pUfiBusWidth] & {pUfiBusWidth{w_gsel[k]}});
      w_adrs_g  = w_adrs_g | (iMUfiAdrs[k*pUsiBusWidth +: pUsiBusWidth] & {pUsiBusWidth{w_gsel[k]}});
    end
  end

  assign w_vd_g  = |(iMUfiVd  & w_gsel);
  assign w_wed_g = |(iMUfiWEd & w_gsel);
  assign w_red_g = |(iMUfiREd & w_gsel);
  assign w_cmd_g = |(iMUfiCmd & w_gsel);
  assign w_gnext = (oGrantId == LAST_ID) ? '0 : (oGrantId + pIdWidth'(1));

  // Release takes priority: a new request is only seen in the following IDLE cycle
  always_comb begin : p_fsm
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_beat_nxt  = r_beat;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    w_rdy_g     = 1'b0;
    w_acc       = 1'b0;
    oMUfiRdy    = '0;
    case (r_state)
      ST_IDLE: begin
        if (|iMUfiVd) begin
          w_grant     = 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        w_rdy_g    = iSUfiRdy & (r_beat < MAX_BEATS);
        oMUfiRdy   = w_gsel & {pMasterNum{w_rdy_g}};
        w_acc      = w_rdy_g & (w_wed_g | w_red_g);
        w_beat_nxt = r_beat + CW'(w_acc);
        if (!w_vd_g || (r_beat == MAX_BEATS)) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = FIXED ? r_ptr : w_gnext;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iSCLK) begin
    if (iSRST) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_beat   <= '0;
      oGrantVd <= 1'b0;
      oGrantId <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_beat  <= w_beat_nxt;
      if (w_grant) begin
        oGrantVd <= 1'b1;
        oGrantId <= w_win;
      end else if (w_release) begin
        oGrantVd <= 1'b0;
      end
    end
  end

  // Slave-side issue: strobes pulse per accepted beat, payload holds otherwise
  always_ff @(posedge iSCLK) begin
    if (iSRST) begin
      oSUfiWd   <= '0;
      oSUfiAdrs <= '0;
      oSUfiWEd  <= 1'b0;
      oSUfiREd  <= 1'b0;
      oSUfiCmd  <= 1'b0;
      oSUfiIdO  <= '0;
    end else begin
      oSUfiWEd <= w_acc & w_wed_g;
      oSUfiREd <= w_acc & w_red_g;
      if (w_acc) begin
        oSUfiWd   <= w_wd_g;
        oSUfiAdrs <= w_adrs_g;
        oSUfiCmd  <= w_cmd_g;
        oSUfiIdO  <= oGrantId;
      end
    end
  end

  // Read return is independent of the grant; out-of-range IDs match no master
  always_ff @(posedge iSCLK) begin
    if (iSRST) begin
      oMUfiRd  <= '0;
      oMUfiREd <= '0;
    end else begin
      oMUfiRd <= iSUfiRd;
      for (int k = 0; k < pMasterNum; k++) begin
        oMUfiREd[k] <= iSUfiREd & (iSUfiIdI == pIdWidth'(k));
      end
    end
  end

endmodule

// File: tb/tb_ufi_master_arbiter.sv
// Randomised bench for ufi_master_arbiter: one "rr" and one "fixed" instance checked
// every cycle against a transaction-level model, plus directed literal scenarios.
module tb_ufi_master_arbiter;
  localparam int N = 4, W = 12, AW = 32, IW = 3, MB0 = 16, MB1 = 5;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, s_red, s_rdy;
  logic [W-1:0] s_rd;
  logic [IW-1:0] s_id;
  logic [N*W-1:0] m_wd [2];
  logic [N*AW-1:0] m_adrs [2];
  logic [N-1:0] m_wed [2], m_red [2], m_cmd [2], m_vd [2];
  logic [N-1:0] o_rdy [2], o_red [2];
  logic [W-1:0] o_rd [2], o_swd [2];
  logic [AW-1:0] o_sadrs [2];
  logic o_swed [2], o_sred [2], o_scmd [2], o_gvd [2];
  logic [IW-1:0] o_sido [2], o_gid [2];

  ufi_master_arbiter #(.pUfiBusWidth(W), .pUsiBusWidth(AW), .pMasterNum(N), .pIdWidth(IW),
                       .pMaxBurst(MB0), .pArbMode("rr")) u_rr (
    .iSCLK(clk), .iSRST(srst), .iMUfiWd(m_wd[0]), .iMUfiAdrs(m_adrs[0]), .iMUfiWEd(m_wed[0]),
    .iMUfiREd(m_red[0]), .iMUfiCmd(m_cmd[0]), .iMUfiVd(m_vd[0]), .oMUfiRdy(o_rdy[0]),
    .oMUfiRd(o_rd[0]), .oMUfiREd(o_red[0]), .oSUfiWd(o_swd[0]), .oSUfiAdrs(o_sadrs[0]),
    .oSUfiWEd(o_swed[0]), .oSUfiREd(o_sred[0]), .oSUfiCmd(o_scmd[0]), .oSUfiIdO(o_sido[0]),
    .iSUfiRd(s_rd), .iSUfiREd(s_red), .iSUfiIdI(s_id), .iSUfiRdy(s_rdy),
    .oGrantVd(o_gvd[0]), .oGrantId(o_gid[0]));

  ufi_master_arbiter #(.pUfiBusWidth(W), .pUsiBusWidth(AW), .pMasterNum(N), .pIdWidth(IW),
                       .pMaxBurst(MB1), .pArbMode("fixed")) u_fx (
    .iSCLK(clk), .iSRST(srst), .iMUfiWd(m_wd[1]), .iMUfiAdrs(m_adrs[1]), .iMUfiWEd(m_wed[1]),
    .iMUfiREd(m_red[1]), .iMUfiCmd(m_cmd[1]), .iMUfiVd(m_vd[1]), .oMUfiRdy(o_rdy[1]),
    .oMUfiRd(o_rd[1]), .oMUfiREd(o_red[1]), .oSUfiWd(o_swd[1]), .oSUfiAdrs(o_sadrs[1]),
    .oSUfiWEd(o_swed[1]), .oSUfiREd(o_sred[1]), .oSUfiCmd(o_scmd[1]), .oSUfiIdO(o_sido[1]),
    .iSUfiRd(s_rd), .iSUfiREd(s_red), .iSUfiIdI(s_id), .iSUfiRdy(s_rdy),
    .oGrantVd(o_gvd[1]), .oGrantId(o_gid[1]));

  // Reference model: grant ownership, beats used, rr pointer, expected registered outputs
  bit busy [2];
  int g [2], beat [2], ptr [2], e_sido [2];
  logic [W-1:0] e_rd [2], e_swd [2];
  logic [N-1:0] e_red [2];
  logic [AW-1:0] e_sadrs [2];
  logic e_swed [2], e_sred [2], e_scmd [2];
  // Master jobs: remaining beats, direction, next address, idle gap before next job
  int jlen [2][N], jidle [2][N];
  bit jrd [2][N];
  logic [AW-1:0] jadr [2][N];

  int n_cmp, n_bad, bubble, low_run;
  bit rand_mode, man_srst, man_rdy, man_red;
  logic [IW-1:0] man_id;
  logic [W-1:0] man_rd;

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    bit_of = 1'b0;
    for (int k = 0; k < N; k++) if (k == i) bit_of = v[k];
  endfunction

  function automatic logic [W-1:0] wsl(input logic [N*W-1:0] v, input int i);
    wsl = '0;
    for (int k = 0; k < N; k++) if (k == i) wsl = v[k*W +: W];
  endfunction

  function automatic logic [AW-1:0] asl(input logic [N*AW-1:0] v, input int i);
    asl = '0;
    for (int k = 0; k < N; k++) if (k == i) asl = v[k*AW +: AW];
  endfunction

  task automatic chk(input string nm, input int u, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t got %0h expected %0h", nm, u, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int mb, base, cand;
    logic acc, rel;
    for (int u = 0; u < 2; u++) begin
      mb = (u == 0) ? MB0 : MB1;
      if (srst) begin
        busy[u] = 1'b0; g[u] = 0; beat[u] = 0; ptr[u] = 0; e_sido[u] = 0;
        e_rd[u] = '0; e_swd[u] = '0; e_red[u] = '0; e_sadrs[u] = '0;
        e_swed[u] = 1'b0; e_sred[u] = 1'b0; e_scmd[u] = 1'b0;
      end else begin
        e_rd[u] = s_rd;
        for (int k = 0; k < N; k++) e_red[u][k] = s_red && (int'(s_id) == k);
        acc = busy[u] && s_rdy && (beat[u] < mb) && (bit_of(m_wed[u], g[u]) || bit_of(m_red[u], g[u]));
        if (acc) begin
          e_swd[u] = wsl(m_wd[u], g[u]);
          e_sadrs[u] = asl(m_adrs[u], g[u]);
          e_swed[u] = bit_of(m_wed[u], g[u]);
          e_sred[u] = bit_of(m_red[u], g[u]);
          e_scmd[u] = bit_of(m_cmd[u], g[u]);
          e_sido[u] = g[u];
          jlen[u][g[u]] = jlen[u][g[u]] - 1;
          jadr[u][g[u]] = jadr[u][g[u]] + 32'd1;
          if (jlen[u][g[u]] == 0) jidle[u][g[u]] = $urandom_range(3, 0);
        end else begin
          e_swed[u] = 1'b0;
          e_sred[u] = 1'b0;
        end
        if (busy[u]) begin
          rel = !bit_of(m_vd[u], g[u]) || (beat[u] == mb);
          if (acc) beat[u] = beat[u] + 1;
          if (rel) begin
            busy[u] = 1'b0;
            if (u == 0) ptr[u] = (g[u] + 1) % N;
          end
        end else if (m_vd[u] != '0) begin
          base = (u == 0) ? ptr[u] : 0;
          for (int i = 0; i < N; i++) begin
            cand = (base + i) % N;
            if (!busy[u] && bit_of(m_vd[u], cand)) begin
              busy[u] = 1'b1; g[u] = cand; beat[u] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic drive();
    logic [31:0] rv;
    logic strobe;
    if (rand_mode) begin
      srst = ($urandom_range(399, 0) == 0);
      if (low_run > 0) begin
        s_rdy = 1'b0; low_run--;
      end else if ($urandom_range(19, 0) == 0) begin
        s_rdy = 1'b0; low_run = $urandom_range(5, 0);
      end else begin
        s_rdy = 1'b1;
      end
      s_red = ($urandom_range(2, 0) == 0);
      rv = $urandom; s_id = rv[IW-1:0];
      rv = $urandom; s_rd = rv[W-1:0];
    end else begin
      srst = man_srst; s_rdy = man_rdy; s_red = man_red; s_id = man_id; s_rd = man_rd;
    end
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < N; k++) begin
        rv = $urandom; m_wd[u][k*W +: W] = rv[W-1:0];
        if (jlen[u][k] > 0) begin
          strobe = ($urandom_range(99, 0) >= bubble);
          m_vd[u][k] = 1'b1;
          m_wed[u][k] = strobe && !jrd[u][k];
          m_red[u][k] = strobe && jrd[u][k];
          m_cmd[u][k] = jrd[u][k];
          m_adrs[u][k*AW +: AW] = jadr[u][k];
        end else begin
          m_vd[u][k] = 1'b0; m_wed[u][k] = 1'b0; m_red[u][k] = 1'b0; m_cmd[u][k] = 1'b0;
          rv = $urandom; m_adrs[u][k*AW +: AW] = rv;
          if (rand_mode) begin
            if (jidle[u][k] > 0) jidle[u][k]--;
            else if ($urandom_range(5, 0) == 0) begin
              jlen[u][k] = $urandom_range(40, 1);
              jrd[u][k] = ($urandom_range(1, 0) == 1);
              rv = $urandom; jadr[u][k] = rv;
            end
          end
        end
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_rdy;
    int mb;
    for (int u = 0; u < 2; u++) begin
      mb = (u == 0) ? MB0 : MB1;
      for (int k = 0; k < N; k++) exp_rdy[k] = busy[u] && s_rdy && (beat[u] < mb) && (g[u] == k);
      chk("rdy", u, 64'(o_rdy[u]), 64'(exp_rdy));
      chk("grant_vd", u, 64'(o_gvd[u]), 64'(busy[u]));
      chk("grant_id", u, 64'(o_gid[u]), 64'(g[u]));
      chk("s_wed", u, 64'(o_swed[u]), 64'(e_swed[u]));
      chk("s_red", u, 64'(o_sred[u]), 64'(e_sred[u]));
      chk("s_wd", u, 64'(o_swd[u]), 64'(e_swd[u]));
      chk("s_adrs", u, 64'(o_sadrs[u]), 64'(e_sadrs[u]));
      chk("s_cmd", u, 64'(o_scmd[u]), 64'(e_scmd[u]));
      chk("s_ido", u, 64'(o_sido[u]), 64'(e_sido[u]));
      chk("m_rd", u, 64'(o_rd[u]), 64'(e_rd[u]));
      chk("m_red", u, 64'(o_red[u]), 64'(e_red[u]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    drive();
    @(negedge clk);
    compare();
  endtask

  int order_q [$], ido_q [$], burst_q [$];
  int cnt, g3_early, beats3;
  logic prev_gvd;
  logic [AW-1:0] last_adr;

  initial begin
    n_cmp = 0; n_bad = 0; bubble = 0; low_run = 0;
    rand_mode = 1'b0; man_srst = 1'b1; man_rdy = 1'b1; man_red = 1'b0; man_id = '0; man_rd = '0;
    srst = 1'b1; s_red = 1'b0; s_rdy = 1'b1; s_rd = '0; s_id = '0;
    for (int u = 0; u < 2; u++) begin
      m_wd[u] = '0; m_adrs[u] = '0; m_wed[u] = '0; m_red[u] = '0; m_cmd[u] = '0; m_vd[u] = '0;
      busy[u] = 1'b0; g[u] = 0; beat[u] = 0; ptr[u] = 0;
      for (int k = 0; k < N; k++) begin
        jlen[u][k] = 0; jidle[u][k] = 0; jrd[u][k] = 1'b0; jadr[u][k] = '0;
      end
    end
    repeat (3) cycle();
    for (int u = 0; u < 2; u++) begin
      chk("reset_gvd", u, 64'(o_gvd[u]), 64'd0);
      chk("reset_gid", u, 64'(o_gid[u]), 64'd0);
      chk("reset_rdy", u, 64'(o_rdy[u]), 64'd0);
      chk("reset_swed", u, 64'(o_swed[u]), 64'd0);
      chk("reset_mred", u, 64'(o_red[u]), 64'd0);
    end
    man_srst = 1'b0;
    cycle();

    // Four masters, four reads each: grants in order 0..3, IDs 0,0,0,0,1,...
    for (int k = 0; k < N; k++) begin
      jlen[0][k] = 4; jrd[0][k] = 1'b1; jadr[0][k] = 32'h40 * k;
    end
    prev_gvd = o_gvd[0];
    for (int c = 0; c < 80; c++) begin
      cycle();
      if (o_gvd[0] && !prev_gvd) order_q.push_back(int'(o_gid[0]));
      if (o_sred[0]) ido_q.push_back(int'(o_sido[0]));
      prev_gvd = o_gvd[0];
    end
    chk("rr_grants", 0, 64'(order_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) chk("rr_order", 0, 64'(order_q[i]), 64'(i));
    chk("rr_reads", 0, 64'(ido_q.size()), 64'd16);
    for (int i = 0; i < 16 && i < ido_q.size(); i++) chk("rr_read_id", 0, 64'(ido_q[i]), 64'(i / 4));

    // Read return routing by ID, 5 is out of range
    man_red = 1'b1; man_id = 3'd1; man_rd = 12'hABC; cycle();
    man_id = 3'd3; man_rd = 12'h123; cycle();
    chk("ret_id1", 0, 64'(o_red[0]), 64'h2);
    chk("ret_d1", 0, 64'(o_rd[0]), 64'hABC);
    man_id = 3'd5; man_rd = 12'h5A5; cycle();
    chk("ret_id3", 0, 64'(o_red[0]), 64'h8);
    chk("ret_d3", 0, 64'(o_rd[0]), 64'h123);
    man_red = 1'b0; cycle();
    chk("ret_id5", 0, 64'(o_red[0]), 64'h0);
    chk("ret_d5", 0, 64'(o_rd[0]), 64'h5A5);

    // 40-beat write from master 2 with a 16-beat cap: bursts 16,16,8
    jlen[0][2] = 40; jrd[0][2] = 1'b0; jadr[0][2] = 32'h100;
    cnt = 0; last_adr = '0; prev_gvd = o_gvd[0];
    for (int c = 0; c < 90; c++) begin
      cycle();
      if (o_swed[0]) begin
        cnt++; last_adr = o_sadrs[0];
      end
      if (prev_gvd && !o_gvd[0]) begin
        burst_q.push_back(cnt); cnt = 0;
      end
      prev_gvd = o_gvd[0];
    end
    chk("cap_bursts", 0, 64'(burst_q.size()), 64'd3);
    if (burst_q.size() == 3) begin
      chk("cap_b0", 0, 64'(burst_q[0]), 64'd16);
      chk("cap_b1", 0, 64'(burst_q[1]), 64'd16);
      chk("cap_b2", 0, 64'(burst_q[2]), 64'd8);
    end
    chk("cap_last_adr", 0, 64'(last_adr), 64'h127);

    // Fixed priority: master 3 waits until master 0 drops Vd
    jlen[1][0] = 30; jrd[1][0] = 1'b0; jadr[1][0] = 32'h0;
    jlen[1][3] = 10; jrd[1][3] = 1'b0; jadr[1][3] = 32'h800;
    g3_early = 0; beats3 = 0;
    for (int c = 0; c < 200; c++) begin
      cycle();
      if (o_gvd[1] && o_gid[1] == 3'd3 && m_vd[1][0]) g3_early++;
      if (o_swed[1] && o_sido[1] == 3'd3) beats3++;
      if (jlen[1][0] == 0 && jlen[1][3] == 0 && !o_gvd[1]) break;
    end
    chk("fixed_starve", 1, 64'(g3_early), 64'd0);
    chk("fixed_m3_beats", 1, 64'(beats3), 64'd10);

    // Reset during beat 7 of a burst from master 1, then clean re-grant
    jlen[0][1] = 20; jrd[0][1] = 1'b0; jadr[0][1] = 32'h300;
    for (int c = 0; c < 40; c++) begin
      if (busy[0] && beat[0] == 7) break;
      cycle();
    end
    chk("rst_reached_beat7", 0, 64'(beat[0]), 64'd7);
    man_srst = 1'b1; cycle();
    man_srst = 1'b0; cycle();
    chk("rst_gvd", 0, 64'(o_gvd[0]), 64'd0);
    chk("rst_swed", 0, 64'(o_swed[0]), 64'd0);
    for (int c = 0; c < 60; c++) begin
      if (jlen[0][1] == 0) break;
      cycle();
    end
    chk("rst_recover", 0, 64'(jlen[0][1]), 64'd0);

    // Randomised traffic: bubbles, slave stalls, random read return, sporadic resets
    rand_mode = 1'b1; bubble = 20;
    repeat (3000) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ufi_master_arbiter.md
Name: ufi_master_arbiter

Overview:
Parametrised N-master arbiter for the UFI bus. It replaces the fixed Mcs/Spi/Vtb/Atb master muxing with a generic front end of pMasterNum masters feeding one UFI slave (RAMUnit). Arbitration is round-robin or fixed-priority, with a burst-length cap so that no master can starve the Vtb and Atb DMA streams. Read data is routed back to the issuing master by transaction ID.

Parameters:
pUfiBusWidth, 12, data width of write data and read data.
pUsiBusWidth, 32, address width.
pMasterNum, 4, number of masters (2..8).
pIdWidth, 3, ID width; must satisfy 2^pIdWidth >= pMasterNum.
pMaxBurst, 16, maximum beats per grant (1..256).
pArbMode, "rr", "rr" selects round-robin; "fixed" gives priority to the lowest index.

Ports:
iSCLK  in  1  bus clock.
iSRST  in  1  synchronous reset, active-high.
iMUfiWd  in  pMasterNum*pUfiBusWidth  per-master write data, master k at slice k.
iMUfiAdrs  in  pMasterNum*pUsiBusWidth  per-master address.
iMUfiWEd  in  pMasterNum  per-master write strobe.
iMUfiREd  in  pMasterNum  per-master read-request strobe.
iMUfiCmd  in  pMasterNum  per-master command: 1 = read, 0 = write.
iMUfiVd  in  pMasterNum  per-master request; high for the whole transfer period.
oMUfiRdy  out  pMasterNum  per-master beat-accept.
oMUfiRd  out  pUfiBusWidth  shared read data.
oMUfiREd  out  pMasterNum  per-master read-data valid.
oSUfiWd  out  pUfiBusWidth  write data to slave.
oSUfiAdrs  out  pUsiBusWidth  address to slave.
oSUfiWEd  out  1  write strobe to slave.
oSUfiREd  out  1  read-request strobe to slave.
oSUfiCmd  out  1  command to slave.
oSUfiIdO  out  pIdWidth  ID of the issuing master.
iSUfiRd  in  pUfiBusWidth  read data from slave.
iSUfiREd  in  1  read-data valid from slave.
iSUfiIdI  in  pIdWidth  ID returned with read data.
iSUfiRdy  in  1  slave can accept beats.
oGrantVd  out  1  a grant is active.
oGrantId  out  pIdWidth  index of the granted master.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, round-robin pointer 0, beat counter 0.
- IDLE state:
  - If iMUfiVd is nonzero, register the winner into oGrantId, set oGrantVd=1, clear the beat counter and move to BUSY.
  - "rr" mode: winner is the first requester at or after the pointer, wrapping modulo pMasterNum.
  - "fixed" mode: winner is the lowest requesting index.
  - No request: stay in IDLE.
- BUSY state, for granted master g:
  - oMUfiRdy[g] = iSUfiRdy & (beat < pMaxBurst), combinational. oMUfiRdy of every other master is 0.
  - A beat is accepted when oMUfiRdy[g] & (iMUfiWEd[g] | iMUfiREd[g]).
  - On each accepted beat, the beat counter increments and the slave-side outputs are registered next edge (latency 1): Wd, Adrs, WEd, REd and Cmd of master g, plus oSUfiIdO=g.
  - On cycles with no accepted beat, oSUfiWEd and oSUfiREd are 0 and the data, address and command outputs hold their last value.
- Release from BUSY:
  - Trigger: iMUfiVd[g] falls, or beat reaches pMaxBurst.
  - Next state is IDLE and oGrantVd goes to 0.
  - "rr" mode sets the pointer to (g+1) mod pMasterNum; "fixed" mode leaves it unchanged.
  - Minimum gap between grants is 1 IDLE cycle.
- Burst cap: at beat == pMaxBurst, oMUfiRdy[g] goes low in the same cycle, even though iMUfiVd[g] is still high. The master keeps Vd asserted and re-arbitrates.
- Slave flow control: the slave must deassert iSUfiRdy with at least 1 beat of slack. The arbiter does not buffer beats.
- Read return: registered, latency 1.
  - oMUfiRd <= iSUfiRd.
  - oMUfiREd[k] <= iSUfiREd & (iSUfiIdI == k).
  - IDs >= pMasterNum are dropped (no strobe).
  - Read return is independent of the FSM and works during other grants.
- Simultaneous events: release and a new request in the same cycle resolve as release first, with the new request arbitrated in the following IDLE cycle. A Vd fall coinciding with an accepted beat counts that beat.
- Reset mid-burst: the FSM, pointer and all outputs return to reset values on the next edge. Read data arriving after reset is routed normally.
- Width rule: the beat counter is clog2(pMaxBurst+1) bits and never wraps.

Test Plan:
1. pMasterNum=4, "rr" mode, masters 0..3 hold Vd with 4 continuous reads each, pMaxBurst=16, iSUfiRdy=1 -> grants in order 0,1,2,3, one IDLE cycle between grants, 16 slave REd pulses carrying oSUfiIdO 0,0,0,0,1,...
2. Master 2 requests a 40-beat write with pMaxBurst=16 and master 1 idle -> bursts of 16, 16 and 8 beats to master 2; oMUfiRdy[2] drops on the 17th cycle; addresses are contiguous at the slave.
3. "fixed" mode, masters 0 and 3 requesting continuously -> master 3 is never granted while master 0 holds Vd; master 3 is granted once Vd[0] falls.
4. Slave returns iSUfiREd with IDs 1, 3, 5 (pMasterNum=4) -> oMUfiREd is 0010 then 1000, ID 5 produces no strobe, oMUfiRd matches iSUfiRd delayed by 1 cycle.
5. iSUfiRdy low for 5 cycles mid-burst -> no beats accepted, beat counter frozen, burst resumes with no data loss.
6. iSRST asserted during beat 7 of a burst -> next cycle oGrantVd=0, oSUfiWEd=0, pointer=0; a fresh request from master 1 is granted cleanly.
